data_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a multi-cycle backing memory.
- The MEM stage stalls while `!is_ready || !is_output_valid`, and holds its request stable during the stall.
- Hits complete in the same cycle the request is presented. Misses use a line-granular valid/ready handshake toward memory.
- Hit and miss counters support performance measurement.

---
 rtl/data_cache.sv | 167 ++++++++++++++++
 tb/tb_data_cache.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the MEM stage
// and a line-granular backing memory, with saturating hit and miss counters.
module data_cache #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic         mem_rw,
  input  logic [31:0]  addr,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic         is_hit,
  output logic [31:0]  dout,
  output logic         mem_req_valid,
  output logic         mem_req_rw,
  output logic [27:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned NUM_SETS  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS  = 28 - INDEX_BITS;
  localparam int unsigned LINE_BITS = 128;

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d;
  logic [NUM_SETS-1:0]   dirty_q, dirty_d;
  logic [31:0]           hit_count_q, hit_count_d;
  logic [31:0]           miss_count_q, miss_count_d;
  logic [TAG_BITS-1:0]   tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0]  data_q [NUM_SETS];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            off;
  logic [TAG_BITS-1:0]   cur_tag;
  logic [LINE_BITS-1:0]  cur_line;
  logic                  req_c;
  logic                  hit_c;
  logic                  line_we;
  logic                  tag_we;
  logic [LINE_BITS-1:0]  line_wdata;
  logic                  unused_addr_bits;

  assign idx              = addr[3+INDEX_BITS:4];
  assign req_tag          = addr[31:4+INDEX_BITS];
  assign off              = addr[3:2];
  assign cur_tag          = tag_q[idx];
  assign cur_line         = data_q[idx];
  assign unused_addr_bits = ^addr[1:0];

  // A request seen while reset is held is treated as no request at all.
  assign req_c = is_input_valid && reset;
  assign hit_c = req_c && valid_q[idx] && (cur_tag == req_tag);

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Next-state, array write controls and the combinational CPU/memory outputs.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    line_we         = 1'b0;
    tag_we          = 1'b0;
    line_wdata      = cur_line;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = 32'd0;
    mem_req_valid   = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = 28'd0;
    mem_req_data    = 128'd0;

    case (state_q)
      IDLE: begin
        is_ready = 1'b1;
        if (!req_c) begin
          is_output_valid = 1'b1;
        end else if (hit_c) begin
          is_output_valid = 1'b1;
          is_hit          = 1'b1;
          if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
          if (mem_rw) begin
            line_we                        = 1'b1;
            line_wdata[{off, 5'd0} +: 32]  = din;
            dirty_d[idx]                   = 1'b1;
          end else begin
            dout = cur_line[{off, 5'd0} +: 32];
          end
        end else begin
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? WB_REQ : FILL_REQ;
        end
      end

      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {cur_tag, idx};
        mem_req_data  = cur_line;
        if (mem_req_ready) begin
          dirty_d[idx] = 1'b0;
          state_d      = FILL_REQ;
        end
      end

      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr[31:4];
        if (mem_req_ready) state_d = FILL_WAIT;
      end

      FILL_WAIT: begin
        if (mem_resp_valid) begin
          line_we      = 1'b1;
          tag_we       = 1'b1;
          line_wdata   = mem_resp_data;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays keep their contents across reset; only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (line_we) data_q[idx] <= line_wdata;
    if (tag_we)  tag_q[idx]  <= req_tag;
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, hand-written corner
// sequences and a randomized run against a line-level cache/memory reference model.
module tb_data_cache;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic         mem_rw;
  logic [31:0]  addr;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic         is_hit;
  logic [31:0]  dout;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  data_cache #(.INDEX_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .is_input_valid(is_input_valid), .mem_rw(mem_rw), .addr(addr), .din(din),
    .is_ready(is_ready), .is_output_valid(is_output_valid), .is_hit(is_hit), .dout(dout),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Background memory contents: every word is distinct and derived from its address.
  function automatic logic [127:0] init_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = {la, 2'(w), 2'b00} ^ 32'hA5C3_0F00;
    return l;
  endfunction

  // ---------------- memory side model (drives the DUT's memory port) ----------------
  typedef struct {
    logic         rw;
    logic [27:0]  la;
    logic [127:0] data;
  } req_t;

  req_t         log_q[$];
  logic [127:0] phys_mem [logic [27:0]];
  int           ready_mode = 0;   // 0 always ready, 1 random, 2 never
  int           lat = 3;
  logic         pend = 1'b0;
  int           cnt = 0;
  logic [27:0]  pend_la = 28'd0;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 128'd0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (!reset) begin
        pend          = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = phys_mem.exists(pend_la) ? phys_mem[pend_la] : init_line(pend_la);
            pend           = 1'b0;
          end else cnt--;
        end
        case (ready_mode)
          0:       mem_req_ready = 1'b1;
          1:       mem_req_ready = 1'($urandom_range(0, 1));
          default: mem_req_ready = 1'b0;
        endcase
      end
      @(negedge clk);
      if (reset && mem_req_valid && mem_req_ready) begin
        log_q.push_back('{mem_req_rw, mem_req_addr, mem_req_data});
        if (mem_req_rw) phys_mem[mem_req_addr] = mem_req_data;
        else begin
          pend    = 1'b1;
          cnt     = lat - 1;
          pend_la = mem_req_addr;
        end
      end
    end
  end

  // ---------------- reference model: whole-line cache + its own memory image ----------------
  logic         mv [16];
  logic         md [16];
  logic [23:0]  mt [16];
  logic [127:0] mline [16];
  logic [127:0] ref_mem [logic [27:0]];
  logic [31:0]  m_hits = 32'd0;
  logic [31:0]  m_misses = 32'd0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    m_hits   = 32'd0;
    m_misses = 32'd0;
  endfunction

  function automatic void model_access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                                       output logic hit, output logic [31:0] rdata,
                                       output logic wb, output logic [27:0] wb_la,
                                       output logic [127:0] wb_data);
    int i;
    int o;
    i       = int'(a[7:4]);
    o       = int'(a[3:2]);
    hit     = mv[i] && (mt[i] == a[31:8]);
    wb      = 1'b0;
    wb_la   = 28'd0;
    wb_data = 128'd0;
    if (!hit) begin
      m_misses++;
      if (mv[i] && md[i]) begin
        wb          = 1'b1;
        wb_la       = {mt[i], 4'(i)};
        wb_data     = mline[i];
        ref_mem[wb_la] = wb_data;
      end
      mline[i] = ref_mem.exists(a[31:4]) ? ref_mem[a[31:4]] : init_line(a[31:4]);
      mt[i]    = a[31:8];
      mv[i]    = 1'b1;
      md[i]    = 1'b0;
    end
    m_hits++;   // the completing access always counts as a hit
    rdata = mline[i][32*o +: 32];
    if (rw) begin
      mline[i][32*o +: 32] = d;
      md[i]                = 1'b1;
    end
  endfunction

  logic [27:0]  last_wb_la;
  logic [127:0] last_wb_data;
  logic [27:0]  last_fill_la;

  // Present one request (entered at posedge+1), follow it to completion, check against model.
  task automatic do_access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                           output logic first_hit, output int nreq, output logic [31:0] fin_dout);
    logic         m_hit, m_wb;
    logic [31:0]  m_rdata;
    logic [27:0]  m_wb_la;
    logic [127:0] m_wb_data;
    int           cyc;
    int           k;
    log_q.delete();
    is_input_valid = 1'b1;
    mem_rw = rw;
    addr   = a;
    din    = d;
    @(negedge clk);
    chk("hit_count_before", 128'(hit_count), 128'(m_hits));
    chk("miss_count_before", 128'(miss_count), 128'(m_misses));
    model_access(rw, a, d, m_hit, m_rdata, m_wb, m_wb_la, m_wb_data);
    first_hit = is_hit;
    chk("first_is_hit", 128'(is_hit), 128'(m_hit));
    chk("first_out_valid", 128'(is_output_valid), 128'(m_hit));
    cyc = 0;
    while (!is_output_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("complete_in_budget", 128'(is_output_valid), 128'(1));
    chk("complete_is_hit", 128'(is_hit), 128'(1));
    chk("complete_dout", 128'(dout), rw ? 128'd0 : 128'(m_rdata));
    fin_dout = dout;
    nreq     = log_q.size();
    chk("mem_req_count", 128'(nreq), m_hit ? 128'd0 : (m_wb ? 128'd2 : 128'd1));
    k = 0;
    if (!m_hit && m_wb && log_q.size() > 0) begin
      chk("wb_rw", 128'(log_q[0].rw), 128'(1));
      chk("wb_addr", 128'(log_q[0].la), 128'(m_wb_la));
      chk("wb_data", log_q[0].data, m_wb_data);
      last_wb_la   = log_q[0].la;
      last_wb_data = log_q[0].data;
      k = 1;
    end
    if (!m_hit && log_q.size() > k) begin
      chk("fill_rw", 128'(log_q[k].rw), 128'(0));
      chk("fill_addr", 128'(log_q[k].la), 128'(a[31:4]));
      last_fill_la = log_q[k].la;
    end
    @(posedge clk); #1;
    is_input_valid = 1'b0;
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_hit;
    int          exp_nreq;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         fh, m_hit, m_wb;
    int           nr, cyc;
    logic [31:0]  fd, m_rdata;
    logic [27:0]  m_wb_la;
    logic [127:0] m_wb_data;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'd0,         1'b0, 1, init_line(28'h10)[31:0]};
    vecs[1] = '{1'b1, 32'h0000_0104, 32'hDEADBEEF,  1'b1, 0, 32'd0};
    vecs[2] = '{1'b0, 32'h0000_0104, 32'd0,         1'b1, 0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 32'h0000_1104, 32'd0,         1'b0, 2, init_line(28'h110)[63:32]};

    reset = 1'b0;
    is_input_valid = 1'b0;
    mem_rw = 1'b0;
    addr = 32'd0;
    din = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_is_ready", 128'(is_ready), 128'(1));
    chk("rst_out_valid", 128'(is_output_valid), 128'(1));
    chk("rst_is_hit", 128'(is_hit), 128'(0));
    chk("rst_dout", 128'(dout), 128'(0));
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_counts", 128'({hit_count, miss_count}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // Idle cycles: always complete, never hit, counters untouched.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out_valid", 128'(is_output_valid), 128'(1));
      chk("idle_is_hit", 128'(is_hit), 128'(0));
      chk("idle_counts", 128'({hit_count, miss_count}), 128'(0));
    end
    @(posedge clk); #1;

    ready_mode = 0;
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      do_access(vecs[i].rw, vecs[i].a, vecs[i].d, fh, nr, fd);
      chk("vec_first_hit", 128'(fh), 128'(vecs[i].exp_hit));
      chk("vec_nreq", 128'(nr), 128'(vecs[i].exp_nreq));
      chk("vec_dout", 128'(fd), 128'(vecs[i].exp_dout));
      if (i == 0) chk("vec0_fill_addr", 128'(last_fill_la), 128'(28'h0000010));
      if (i == 3) begin
        chk("vec3_wb_addr", 128'(last_wb_la), 128'(28'h0000010));
        chk("vec3_wb_word1", 128'(last_wb_data[63:32]), 128'(32'hDEADBEEF));
        chk("vec3_fill_addr", 128'(last_fill_la), 128'(28'h0000110));
      end
    end
    @(negedge clk);
    chk("vec_hit_count", 128'(hit_count), 128'(4));
    chk("vec_miss_count", 128'(miss_count), 128'(2));
    @(posedge clk); #1;

    // Fill request held off by the memory for 5 cycles.
    ready_mode = 2;
    log_q.delete();
    model_access(1'b0, 32'h0000_2200, 32'd0, m_hit, m_rdata, m_wb, m_wb_la, m_wb_data);
    is_input_valid = 1'b1;
    mem_rw = 1'b0;
    addr = 32'h0000_2200;
    @(negedge clk);
    chk("hold_first_miss", 128'(is_output_valid), 128'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req_valid", 128'(mem_req_valid), 128'(1));
      chk("hold_req_rw", 128'(mem_req_rw), 128'(0));
      chk("hold_req_addr", 128'(mem_req_addr), 128'(28'h0000220));
      chk("hold_is_ready", 128'(is_ready), 128'(0));
    end
    ready_mode = 0;
    cyc = 0;
    while (!is_output_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_complete", 128'(is_output_valid), 128'(1));
    chk("hold_dout", 128'(dout), 128'(m_rdata));
    @(posedge clk); #1;
    is_input_valid = 1'b0;

    // Reset while waiting for a fill response.
    lat = 20;
    log_q.delete();
    is_input_valid = 1'b1;
    addr = 32'h0000_0300;
    cyc = 0;
    while (log_q.size() == 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_fill_seen", 128'(log_q.size()), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_is_ready", 128'(is_ready), 128'(1));
    chk("rstmid_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rstmid_out_valid", 128'(is_output_valid), 128'(1));
    chk("rstmid_is_hit", 128'(is_hit), 128'(0));
    is_input_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    lat = 3;
    do_access(1'b0, 32'h0000_0100, 32'd0, fh, nr, fd);
    chk("reload_first_hit", 128'(fh), 128'(0));
    @(negedge clk);
    chk("reload_miss_count", 128'(miss_count), 128'(1));
    chk("reload_hit_count", 128'(hit_count), 128'(1));
    @(posedge clk); #1;

    // Randomized traffic over a few tags so hits, clean misses and dirty evictions all occur.
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra;
      lat = int'($urandom_range(1, 4));
      ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      do_access(1'($urandom_range(0, 1)), ra, $urandom, fh, nr, fd);
    end
    @(negedge clk);
    chk("final_hit_count", 128'(hit_count), 128'(m_hits));
    chk("final_miss_count", 128'(miss_count), 128'(m_misses));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
